// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one write port, post-reset scrub.
// Optional write-through forwarding when RF_BYPASS_EN is defined.
module reg_file_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] rs_out,
    output logic [DATA_W-1:0] rt_out,
    output logic              ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
    logic [DATA_W-1:0] rs_out_q, rs_out_d;
    logic [DATA_W-1:0] rt_out_q, rt_out_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr_blocked;
    logic              last_entry;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;

    // Entry 0 is hardwired to zero only in the ZERO_R0 build.
    assign wr_blocked = (ZERO_R0 != 0) && (rd == '0);
    assign last_entry = (scrub_cnt_q == {ADDR_W{1'b1}});
    assign rs_rd      = ((ZERO_R0 != 0) && (rs == '0)) ? '0 : rf_q[rs];
    assign rt_rd      = ((ZERO_R0 != 0) && (rt == '0)) ? '0 : rf_q[rt];

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        ready_d     = ready_q;
        rs_out_d    = '0;
        rt_out_d    = '0;
        we          = 1'b0;
        waddr       = rd;
        wdata       = data_in;
        case (state_q)
            SCRUB: begin
                we    = 1'b1;
                waddr = scrub_cnt_q;
                wdata = '0;
                if (last_entry) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + ADDR_W'(1);
                end
            end
            RUN: begin
                we       = wrt && !wr_blocked;
                rs_out_d = rs_rd;
                rt_out_d = rt_rd;
`ifdef RF_BYPASS_EN
                if (wrt && !wr_blocked && (rd == rs)) rs_out_d = data_in;
                if (wrt && !wr_blocked && (rd == rt)) rt_out_d = data_in;
`endif
            end
            default: state_d = SCRUB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
            ready_q     <= 1'b0;
            rs_out_q    <= '0;
            rt_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            ready_q     <= ready_d;
            rs_out_q    <= rs_out_d;
            rt_out_q    <= rt_out_d;
        end
    end

    // Storage has no reset; the scrub pass clears it.
    always_ff @(posedge clk) begin
        if (we) rf_q[waddr] <= wdata;
    end

    assign rs_out = rs_out_q;
    assign rt_out = rt_out_q;
    assign ready  = ready_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default, ZERO_R0=1 and 16x8 instances
// share stimulus and are compared each cycle against a behavioural model.
module tb_reg_file_param;
    logic        clk;
    logic        rst;
    logic        wrt;
    logic [5:0]  rd, rs, rt;
    logic [31:0] data_in;
    logic [31:0] o0s, o0t, o1s, o1t;
    logic [15:0] o2s, o2t;
    logic        r0, r1, r2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    reg_file_param #(.DATA_W(32), .ADDR_W(6), .ZERO_R0(0)) u0 (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd), .rs(rs), .rt(rt),
        .data_in(data_in), .rs_out(o0s), .rt_out(o0t), .ready(r0));
    reg_file_param #(.DATA_W(32), .ADDR_W(6), .ZERO_R0(1)) u1 (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd), .rs(rs), .rt(rt),
        .data_in(data_in), .rs_out(o1s), .rt_out(o1t), .ready(r1));
    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) u2 (
        .clk(clk), .rst(rst), .wrt(wrt), .rd(rd[2:0]), .rs(rs[2:0]), .rt(rt[2:0]),
        .data_in(data_in[15:0]), .rs_out(o2s), .rt_out(o2t), .ready(r2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents are zero after any reset; the file is usable
    // once DEPTH edges have elapsed since reset release.
    logic [31:0] m0 [64];
    logic [31:0] m1 [64];
    logic [15:0] m2 [8];
    int          cnt;
    logic [31:0] e0s, e0t, e1s, e1t;
    logic [15:0] e2s, e2t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt = 0;
            e0s = 0; e0t = 0; e1s = 0; e1t = 0; e2s = 0; e2t = 0;
            for (int i = 0; i < 64; i++) begin m0[i] = 0; m1[i] = 0; end
            for (int i = 0; i < 8; i++) m2[i] = 0;
        end else begin
            if (cnt >= 64) begin
                e0s = m0[rs];
                e0t = m0[rt];
                e1s = (rs == 0) ? 32'h0 : m1[rs];
                e1t = (rt == 0) ? 32'h0 : m1[rt];
`ifdef RF_BYPASS_EN
                if (wrt && rd == rs) e0s = data_in;
                if (wrt && rd == rt) e0t = data_in;
                if (wrt && rd == rs && rd != 0) e1s = data_in;
                if (wrt && rd == rt && rd != 0) e1t = data_in;
`endif
                if (wrt) m0[rd] = data_in;
                if (wrt && rd != 0) m1[rd] = data_in;
            end else begin
                e0s = 0; e0t = 0; e1s = 0; e1t = 0;
            end
            if (cnt >= 8) begin
                e2s = m2[rs[2:0]];
                e2t = m2[rt[2:0]];
`ifdef RF_BYPASS_EN
                if (wrt && rd[2:0] == rs[2:0]) e2s = data_in[15:0];
                if (wrt && rd[2:0] == rt[2:0]) e2t = data_in[15:0];
`endif
                if (wrt) m2[rd[2:0]] = data_in[15:0];
            end else begin
                e2s = 0; e2t = 0;
            end
            if (cnt < 1000) cnt = cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("u0_rs_out", o0s, e0s);
            cmp("u0_rt_out", o0t, e0t);
            cmp("u0_ready", {31'b0, r0}, {31'b0, cnt >= 64});
            cmp("u1_rs_out", o1s, e1s);
            cmp("u1_rt_out", o1t, e1t);
            cmp("u1_ready", {31'b0, r1}, {31'b0, cnt >= 64});
            cmp("u2_rs_out", {16'b0, o2s}, {16'b0, e2s});
            cmp("u2_rt_out", {16'b0, o2t}, {16'b0, e2t});
            cmp("u2_ready", {31'b0, r2}, {31'b0, cnt >= 8});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic scrub_run(input bool_late_write);
        for (int i = 1; i <= 64; i++) begin
            if (bool_late_write && i == 10) begin
                wrt = 1; rd = 3; data_in = 32'h12345678;
            end else begin
                wrt = 0;
            end
            step();
            if (i == 7)  cmp("u2_ready_edge7", {31'b0, r2}, 32'd0);
            if (i == 8)  cmp("u2_ready_edge8", {31'b0, r2}, 32'd1);
            if (i == 63) cmp("u0_ready_edge63", {31'b0, r0}, 32'd0);
            if (i == 64) cmp("u0_ready_edge64", {31'b0, r0}, 32'd1);
        end
        wrt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; wrt = 0; rd = 0; rs = 0; rt = 0; data_in = 0;
        #1 rst = 1;
        chk_en = 1;
        step();
        cmp("reset_rs_out", o0s, 32'h0);
        cmp("reset_ready", {31'b0, r0}, 32'd0);
        step();
        rst = 0;

        // Scrub with a write attempt on edge 10 that must be dropped.
        scrub_run(1);

        // Full read sweep: everything reads zero.
        for (int a = 0; a < 64; a++) begin
            rs = 6'(a); rt = 6'(63 - a);
            step();
            if (a == 3) cmp("scrub_write_dropped", o0s, 32'h0);
        end

        // Simple write then read on both ports.
        wrt = 1; rd = 5; data_in = 32'hDEADBEEF; rs = 0; rt = 1;
        step();
        wrt = 0; rs = 5; rt = 5;
        step();
        cmp("wr5_rs_out", o0s, 32'hDEADBEEF);
        cmp("wr5_rt_out", o0t, 32'hDEADBEEF);
        cmp("wr5_u2_rs_out", {16'b0, o2s}, 32'h0000BEEF);

        // Same-edge write/read collision.
        wrt = 1; rd = 7; data_in = 32'h00000011; rs = 0;
        step();
        wrt = 1; rd = 7; data_in = 32'h00000022; rs = 7; rt = 5;
        step();
`ifdef RF_BYPASS_EN
        cmp("collide_rs_out", o0s, 32'h00000022);
`else
        cmp("collide_rs_out", o0s, 32'h00000011);
`endif
        wrt = 0;
        step();
        cmp("after_collide_rs_out", o0s, 32'h00000022);

        // Entry 0 write: dropped in u1, ordinary in u0.
        wrt = 1; rd = 0; data_in = 32'hFFFFFFFF; rs = 0; rt = 0;
        step();
        cmp("zero_r0_same_edge", o1s, 32'h0);
        wrt = 0;
        step();
        cmp("zero_r0_read", o1s, 32'h0);
        cmp("r0_ordinary_read", o0s, 32'hFFFFFFFF);

        // Mixed traffic with overlapping addresses, checked by the model.
        for (int i = 0; i < 24; i++) begin
            wrt = (i % 3) != 2;
            rd = 6'((i * 5) % 64);
            data_in = 32'hA5000000 ^ (i * 32'h01010101);
            rs = 6'(((i - 1) * 5) % 64);
            rt = (i % 4 == 0) ? rd : rs;
            step();
        end
        wrt = 0;

        // Mid-operation asynchronous reset.
        wrt = 1; rd = 9; data_in = 32'hCAFEF00D;
        step();
        wrt = 0; rs = 9; rt = 9;
        step();
        cmp("wr9_rs_out", o0s, 32'hCAFEF00D);
        #2 rst = 1;
        #1;
        cmp("async_rst_rs_out", o0s, 32'h0);
        cmp("async_rst_rt_out", o0t, 32'h0);
        cmp("async_rst_ready", {31'b0, r0}, 32'd0);
        cmp("async_rst_u2_ready", {31'b0, r2}, 32'd0);
        step();
        rst = 0;
        scrub_run(0);
        step();
        cmp("rescrub_entry9", o0s, 32'h0);
        cmp("rescrub_u2_entry1", {16'b0, o2s}, 32'h0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
